aes_128_arbiter_2req: RTL
=========================

# aes_128_arbiter_2req

Two-port round-robin arbiter that shares a single `aes_128_core_full_4cyc` instance between two independent block requesters. It buffers one input block per port and issues at most one block to the core at a time. It tracks the owner of the in-flight block and routes `core_out_data` back to that owner's response buffer. A busy-timeout watchdog kills a hung core operation. The block sits between the requester-side interconnect and the AES core wrapper.

## Interface
Parameters:
- `TIMEOUT`, 64: maximum cycles in BUSY before abort. Legal range 2..255.

Ports (name, direction, width, meaning):
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous active-low reset.
- `kill` in 1: synchronous abort of everything. It is forwarded to the core.
- `req0_data` / `req1_data` in 128: plaintext block per port.
- `req0_valid` / `req1_valid` in 1: request valid.
- `req0_ready` / `req1_ready` out 1: request ready.
- `resp0_data` / `resp1_data` out 128: result block.
- `resp0_valid` / `resp1_valid` out 1: result valid.
- `resp0_ready` / `resp1_ready` in 1: result accepted.
- `core_in_data` out 128: block to the core.
- `core_in_en` out 1: one-cycle issue pulse, registered.
- `core_kill` out 1: equal to `kill` OR the abort pulse.
- `core_out_data` in 128: core result.
- `core_out_en` in 1: core result strobe.
- `owner` out 1: id of the in-flight requester. The external key schedule uses it to select the key set.
- `busy` out 1: a block is in flight.
- `timeout_irq_pulse` out 1: one-cycle pulse on watchdog abort.
- `timeout_id` out 1: owner id of the aborted block. Holds until the next abort.

## Operation
Request buffers:
- Each port has a one-deep pending register `pend_i`.
- `reqi_ready = ~pend_i`.
- When `reqi_valid & reqi_ready`, the block latches and `pend_i` is set.

Eligibility and arbitration:
- Port i is eligible when `pend_i & ~respi_valid`. This guarantees its response slot is free when the core finishes, because the core cannot stall.
- A round-robin pointer `last` gives priority to the port not granted last. Its reset value is 1, so port 0 wins first.

FSM states are IDLE, BUSY and ABORT:
- **IDLE**
  - If any port is eligible: grant it, drive `core_in_data`, pulse `core_in_en` for 1 cycle, clear its `pend_i`, set `owner`, update `last`, then go to BUSY.
  - Otherwise stay in IDLE.
- **BUSY**
  - The watchdog counter counts from 0.
  - On `core_out_en`: capture `core_out_data` into `resp[owner]`, set `resp[owner]_valid`, then go to IDLE.
  - If the counter reaches `TIMEOUT-1` without `core_out_en`: go to ABORT.
- **ABORT**
  - For one cycle: `core_kill=1`, `timeout_irq_pulse=1`, `timeout_id=owner`.
  - The owner's block is dropped and no response is produced.
  - Next state is IDLE.

Response buffers:
- A response slot is cleared when `respi_valid & respi_ready`.
- A request for a port can be accepted while that port's response is pending, but that port is not issued until its response is drained.

## Timing
- Reset values:
  - all `pend`, `respi_valid`, `core_in_en`, `core_kill`, `busy` and `timeout_irq_pulse` are 0;
  - `owner`, `timeout_id` and all data outputs are 0;
  - `reqi_ready` is 1;
  - state is IDLE.
- Request accepted at edge N, with the FSM in IDLE and the port eligible: `core_in_en` is high in cycle N+1 and `busy` rises in cycle N+2.
- `core_out_en` sampled at edge M: `respi_valid` is high in cycle M+1 and the FSM is in IDLE in M+1.
  - The earliest next `core_in_en` is cycle M+2.
  - The minimum gap between `core_out_en` and the next `core_in_en` is one cycle.
- A request arriving in the same cycle as its own response is drained is accepted. That port is eligible in the following cycle.
- `core_out_en` in the same cycle the watchdog expires: the completion wins and no abort occurs.
- `core_out_en` while in IDLE or ABORT is spurious and ignored. No response is written.
- `kill` asserted in any state:
  - next cycle all `pend` and `respi_valid` are 0 and the state is IDLE;
  - `last` and `timeout_id` are kept;
  - `core_kill` follows `kill` combinationally.
- Asserting `rst_n` mid-operation clears everything immediately (asynchronous).
- The watchdog counter is 8 bits and resets to 0 on every entry to BUSY. It never wraps.

## Structure
- Shared package `aes_128_pkg` holds:
  - the state enum `{IDLE, BUSY, ABORT}`;
  - `AES_BLOCK_W=128`;
  - the default timeout constant.
- One sub-module is natural: `aes_128_rr_arb2`, a 2-way round-robin grant with its pointer register.
- Request and response buffers, the FSM and the watchdog are inline.

## Test plan
- Single request: `req0_data=0x00112233445566778899aabbccddeeff`. The core model returns a fixed result 44 cycles after `core_in_en` → `resp0_valid` one cycle after `core_out_en` with the matching data, and `owner=0` throughout BUSY.
- Simultaneous `req0_valid` and `req1_valid` after reset → grants go 0, 1, 0, 1 over four back-to-back requests per port. Each response returns on the correct port and `core_in_en` never fires while `busy=1`.
- Hold `resp0_ready=0` with a second req0 pending while req1 is idle → port 0 is not reissued. Raising `resp0_ready` allows issue two cycles later.
- Core model never asserts `core_out_en`, with `TIMEOUT=64` → a single `core_kill` and `timeout_irq_pulse` occur exactly 64 cycles after `busy` rises, with `timeout_id=owner`. No response is produced and the other port is served afterwards.
- `core_out_en` coincides with the last watchdog cycle → the response is delivered and there is no abort pulse.
- `kill` mid-BUSY with both ports pending → `core_kill=1` in the same cycle. Next cycle all valids are 0, both readys are 1 and a late `core_out_en` is ignored.

Source files
------------

// File: rtl/aes_128_pkg.sv
`default_nettype none
// ============================================================================
// aes_128_pkg : shared types and constants for the AES-128 two-port arbiter
// Revision    : 1.0
// ============================================================================
package aes_128_pkg;

    localparam int AES_BLOCK_W     = 128;
    localparam int DEFAULT_TIMEOUT = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        ABORT = 2'd2
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/aes_128_rr_arb2.sv
`default_nettype none
// ============================================================================
// aes_128_rr_arb2 : 2-way round-robin grant with its last-granted pointer
// Revision        : 1.0
// ============================================================================
module aes_128_rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_i,
    input  logic       advance_i,
    output logic       any_o,
    output logic       gnt_id_o
);

    logic last_q;

    // The port not granted last wins a tie; a lone requester always wins.
    always_comb begin
        any_o = |req_i;
        if (last_q) begin
            gnt_id_o = ~req_i[0];
        end else begin
            gnt_id_o = req_i[1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else if (advance_i && any_o) begin
            last_q <= gnt_id_o;
        end
    end

endmodule
`default_nettype wire

// File: rtl/aes_128_arbiter_2req.sv
`default_nettype none
// ============================================================================
// aes_128_arbiter_2req : shares one AES-128 core between two block requesters
// Revision             : 1.0
// ============================================================================
module aes_128_arbiter_2req
    import aes_128_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   kill,
    input  logic [AES_BLOCK_W-1:0] req0_data,
    input  logic                   req0_valid,
    output logic                   req0_ready,
    input  logic [AES_BLOCK_W-1:0] req1_data,
    input  logic                   req1_valid,
    output logic                   req1_ready,
    output logic [AES_BLOCK_W-1:0] resp0_data,
    output logic                   resp0_valid,
    input  logic                   resp0_ready,
    output logic [AES_BLOCK_W-1:0] resp1_data,
    output logic                   resp1_valid,
    input  logic                   resp1_ready,
    output logic [AES_BLOCK_W-1:0] core_in_data,
    output logic                   core_in_en,
    output logic                   core_kill,
    input  logic [AES_BLOCK_W-1:0] core_out_data,
    input  logic                   core_out_en,
    output logic                   owner,
    output logic                   busy,
    output logic                   timeout_irq_pulse,
    output logic                   timeout_id
);

    localparam logic [7:0] c_wd_last = 8'(TIMEOUT - 1);

    arb_state_t             state_q, state_d;
    logic [1:0]             pend_q, pend_d;
    logic [1:0]             rvalid_q, rvalid_d;
    logic [AES_BLOCK_W-1:0] req0_buf_q, req0_buf_d;
    logic [AES_BLOCK_W-1:0] req1_buf_q, req1_buf_d;
    logic [AES_BLOCK_W-1:0] resp0_q, resp0_d;
    logic [AES_BLOCK_W-1:0] resp1_q, resp1_d;
    logic [AES_BLOCK_W-1:0] cin_q, cin_d;
    logic                   cin_en_q, cin_en_d;
    logic                   owner_q, owner_d;
    logic                   busy_q, busy_d;
    logic                   tid_q, tid_d;
    logic [7:0]             wd_q, wd_d;

    logic [1:0]             w_elig;
    logic                   w_issue;
    logic                   w_arb_any;
    logic                   w_arb_id;

    // A port with an undrained response is held back so its slot is free on completion.
    assign w_elig  = pend_q & ~rvalid_q;
    assign w_issue = (state_q == IDLE) && !kill;

    aes_128_rr_arb2 u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_i     (w_elig),
        .advance_i (w_issue),
        .any_o     (w_arb_any),
        .gnt_id_o  (w_arb_id)
    );

    always_comb begin
        state_d    = state_q;
        pend_d     = pend_q;
        rvalid_d   = rvalid_q;
        req0_buf_d = req0_buf_q;
        req1_buf_d = req1_buf_q;
        resp0_d    = resp0_q;
        resp1_d    = resp1_q;
        cin_d      = cin_q;
        cin_en_d   = 1'b0;
        owner_d    = owner_q;
        tid_d      = tid_q;
        wd_d       = wd_q;

        if (kill) begin
            pend_d   = 2'b00;
            rvalid_d = 2'b00;
            state_d  = IDLE;
            wd_d     = 8'd0;
        end else begin
            if (req0_valid && !pend_q[0]) begin
                pend_d[0]  = 1'b1;
                req0_buf_d = req0_data;
            end
            if (req1_valid && !pend_q[1]) begin
                pend_d[1]  = 1'b1;
                req1_buf_d = req1_data;
            end
            if (rvalid_q[0] && resp0_ready) rvalid_d[0] = 1'b0;
            if (rvalid_q[1] && resp1_ready) rvalid_d[1] = 1'b0;

            unique case (state_q)
                IDLE: begin
                    if (w_arb_any) begin
                        pend_d[w_arb_id] = 1'b0;
                        cin_d            = w_arb_id ? req1_buf_q : req0_buf_q;
                        cin_en_d         = 1'b1;
                        owner_d          = w_arb_id;
                        wd_d             = 8'd0;
                        state_d          = BUSY;
                    end
                end
                BUSY: begin
                    // Completion takes precedence over an expiring watchdog.
                    if (core_out_en) begin
                        rvalid_d[owner_q] = 1'b1;
                        if (owner_q) resp1_d = core_out_data;
                        else         resp0_d = core_out_data;
                        state_d = IDLE;
                    end else if (wd_q == c_wd_last) begin
                        tid_d   = owner_q;
                        state_d = ABORT;
                    end else if (busy_q) begin
                        wd_d = wd_q + 8'd1;
                    end
                end
                ABORT: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        // busy trails the issue pulse by a cycle and drops as the block leaves BUSY.
        busy_d = (state_q == BUSY) && (state_d == BUSY);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pend_q     <= 2'b00;
            rvalid_q   <= 2'b00;
            req0_buf_q <= '0;
            req1_buf_q <= '0;
            resp0_q    <= '0;
            resp1_q    <= '0;
            cin_q      <= '0;
            cin_en_q   <= 1'b0;
            owner_q    <= 1'b0;
            busy_q     <= 1'b0;
            tid_q      <= 1'b0;
            wd_q       <= 8'd0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            rvalid_q   <= rvalid_d;
            req0_buf_q <= req0_buf_d;
            req1_buf_q <= req1_buf_d;
            resp0_q    <= resp0_d;
            resp1_q    <= resp1_d;
            cin_q      <= cin_d;
            cin_en_q   <= cin_en_d;
            owner_q    <= owner_d;
            busy_q     <= busy_d;
            tid_q      <= tid_d;
            wd_q       <= wd_d;
        end
    end

    assign req0_ready        = ~pend_q[0];
    assign req1_ready        = ~pend_q[1];
    assign resp0_valid       = rvalid_q[0];
    assign resp1_valid       = rvalid_q[1];
    assign resp0_data        = resp0_q;
    assign resp1_data        = resp1_q;
    assign core_in_data      = cin_q;
    assign core_in_en        = cin_en_q;
    assign core_kill         = kill || (state_q == ABORT);
    assign timeout_irq_pulse = (state_q == ABORT);
    assign owner             = owner_q;
    assign busy              = busy_q;
    assign timeout_id        = tid_q;

endmodule
`default_nettype wire
